i2c_slave_receiver: RTL

I2C_SLAVE_RECEIVER -- requirements
Module: i2c_slave_receiver

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_bus_sync.sv | 53 +++++
 rtl/i2c_slave_receiver.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and bus-condition patterns.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the bus master uses the same START/STOP patterns.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } i2c_state_t;

    // {previous SDA, current SDA} while SCL is held high.
    localparam logic [1:0] SDA_START = 2'b10;
    localparam logic [1:0] SDA_STOP  = 2'b01;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into clk and flags SCL edges plus START/STOP conditions.
// Latency: SYNC_STAGES flops plus one history flop; detect outputs are combinational from those.
// Backpressure: none; every bus change is reported exactly once.
// Ports: clk, rst_n (async, active-low); scl, sda raw bus inputs;
//        scl_rise, scl_fall, start_det, stop_det single-clk pulses; sda_s synchronized SDA.
module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    // Preset to 1 so a reset looks like an idle bus and never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;

    // SCL must be high on both samples so an SDA change racing an SCL edge is not a condition.
    assign start_det = scl_s & scl_d & ({sda_d, sda_s} == SDA_START);
    assign stop_det  = scl_s & scl_d & ({sda_d, sda_s} == SDA_STOP);

endmodule

// File: rtl/i2c_slave_receiver.sv
// Write-only I2C target: matches SLAVE_ADDR, ACKs address and data bytes, presents each byte.
// Latency: rx_valid 1 clk after the synchronized 8th SCL rise (~SYNC_STAGES+1 clk after the pin).
// Backpressure: none; rx_data is overwritten by the next byte, no clock stretching.
// Ports: clk, rst_n (async, active-low); SCL input; SDA open-drain inout;
//        rx_data/rx_valid received byte and strobe; addr_hit address matched; busy START..STOP.
module i2c_slave_receiver
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SCL,
    inout  wire        SDA,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_hit,
    output logic       busy
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (SCL),
        .sda       (SDA),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_state_t state, state_n;
    logic [7:0] shift, shift_n, shifted;
    logic [2:0] cnt, cnt_n;
    logic       ack_phase, ack_phase_n;  // 0: waiting for first fall, 1: holding SDA low
    logic       sda_oe, sda_oe_n;
    logic [7:0] rx_data_n;
    logic       rx_valid_n, addr_hit_n, busy_n;

    assign SDA = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift     <= 8'h00;
            cnt       <= 3'd0;
            ack_phase <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            addr_hit  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            shift     <= shift_n;
            cnt       <= cnt_n;
            ack_phase <= ack_phase_n;
            sda_oe    <= sda_oe_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            addr_hit  <= addr_hit_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        shift_n     = shift;
        cnt_n       = cnt;
        ack_phase_n = ack_phase;
        sda_oe_n    = sda_oe;
        rx_data_n   = rx_data;
        rx_valid_n  = 1'b0;
        addr_hit_n  = addr_hit;
        busy_n      = busy;
        shifted     = {shift[6:0], sda_s};

        // Bus conditions outrank SCL edges; a half-received byte simply dies here.
        if (stop_det) begin
            state_n     = IDLE;
            cnt_n       = 3'd0;
            ack_phase_n = 1'b0;
            sda_oe_n    = 1'b0;
            addr_hit_n  = 1'b0;
            busy_n      = 1'b0;
        end else if (start_det) begin
            state_n     = ADDR;
            cnt_n       = 3'd0;
            ack_phase_n = 1'b0;
            sda_oe_n    = 1'b0;
            addr_hit_n  = 1'b0;
            busy_n      = 1'b1;
        end else begin
            case (state)
                ADDR, DATA: begin
                    if (scl_rise) begin
                        shift_n = shifted;
                        cnt_n   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            ack_phase_n = 1'b0;
                            if (state == DATA) begin
                                rx_data_n  = shifted;
                                rx_valid_n = 1'b1;
                                state_n    = DATA_ACK;
                            end else if (shifted[7:1] == SLAVE_ADDR && !shifted[0]) begin
                                state_n = ADDR_ACK;
                            end else begin
                                state_n = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            ack_phase_n = 1'b1;
                            sda_oe_n    = 1'b1;
                        end else begin
                            ack_phase_n = 1'b0;
                            sda_oe_n    = 1'b0;
                            cnt_n       = 3'd0;
                            state_n     = DATA;
                            if (state == ADDR_ACK) begin
                                addr_hit_n = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    // IDLE and IGNORE wait for a bus condition only.
                end
            endcase
        end
    end

endmodule
